// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared types and constants for the watch front-panel controller
// Mode/flag codes match what STOPWATCH decodes; cmd_state_t is internal to watch_ctrl.
package watch_pkg;

  typedef enum logic [1:0] {
    CLOCK     = 2'd0,
    STOPWATCH = 2'd1,
    TIMER     = 2'd2,
    ALARM     = 2'd3
  } mode_t;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CLEAR = 4'd5,
    PAUSE = 4'd6,
    RUN   = 4'd7
  } flag_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_CLR1,
    S_CLR2
  } cmd_state_t;

  localparam int BTN_MODE  = 0;
  localparam int BTN_START = 1;
  localparam int BTN_CLEAR = 2;
  localparam int NUM_BTN   = 3;

  // Both clear states present CLEAR so the stopwatch sees a two-cycle clear strobe.
  function automatic flag_t cmd_to_flag(input cmd_state_t s);
    case (s)
      S_RUN:           return RUN;
      S_PAUSE:         return PAUSE;
      S_CLR1, S_CLR2:  return CLEAR;
      default:         return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/watch_if.sv
// rtl/watch_if.sv - button/mode/command bundle between the panel controller and STOPWATCH
interface watch_if;
  logic [7:0] btn_n;
  logic [3:0] state;
  logic [3:0] flag;

  modport master (input btn_n, output state, output flag);
  modport slave  (output btn_n, input state, input flag);
endinterface

// File: rtl/watch_ctrl_btn_debounce.sv
// rtl/watch_ctrl_btn_debounce.sv - per-button synchroniser, debounce counter and press detector
// o_press pulses for one cycle on the registered cycle after the debounced level falls.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
        // Level accepted: only the high-to-low flip is a press.
        r_level <= r_sync2;
        r_press <= ~r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/watch_ctrl.sv
// rtl/watch_ctrl.sv - front-panel controller: debounced buttons to STOPWATCH mode/command codes
// Holds the mode register and the stopwatch command FSM; MODE > START > CLEAR per cycle.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  watch_if.master  bus
);

  logic [NUM_BTN-1:0] w_press;
  logic               w_mode_ev;
  logic               w_start_ev;
  logic               w_clear_ev;
  mode_t              r_mode;
  cmd_state_t         r_cmd;
  cmd_state_t         w_cmd_next;
  flag_t              r_flag;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn_n (bus.btn_n[g]),
      .o_press (w_press[g])
    );
  end

  // A higher-priority event suppresses lower ones even when it is itself ignored.
  assign w_mode_ev  = w_press[BTN_MODE];
  assign w_start_ev = w_press[BTN_START] & ~w_press[BTN_MODE];
  assign w_clear_ev = w_press[BTN_CLEAR] & ~w_press[BTN_START] & ~w_press[BTN_MODE];

  always_comb begin
    w_cmd_next = r_cmd;
    case (r_cmd)
      S_CLR1:  w_cmd_next = S_CLR2;
      S_CLR2:  w_cmd_next = S_IDLE;
      default: w_cmd_next = r_cmd;
    endcase
    if (w_start_ev && r_mode == STOPWATCH) begin
      w_cmd_next = (r_cmd == S_RUN) ? S_PAUSE : S_RUN;
    end else if (w_clear_ev && r_mode == STOPWATCH && r_cmd != S_RUN) begin
      w_cmd_next = S_CLR1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= STOPWATCH;
      r_cmd  <= S_IDLE;
      r_flag <= IDLE;
    end else begin
      if (w_mode_ev) begin
        r_mode <= mode_t'(r_mode + 2'd1);
      end
      r_cmd  <= w_cmd_next;
      r_flag <= cmd_to_flag(w_cmd_next);
    end
  end

  assign bus.state = {2'b00, r_mode};
  assign bus.flag  = r_flag;

endmodule

// File: tb/tb_watch_ctrl.sv
// tb/tb_watch_ctrl.sv - self-checking bench for watch_ctrl against a behavioural panel model
module tb_watch_ctrl;

  localparam int D = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  watch_if bus ();

  watch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: a button level is accepted once D+1 consecutive samples, seen two
  // clocks late through the synchroniser, all disagree with the accepted level.
  logic hist [3][D+2];
  logic m_db [3];
  logic m_ev [3];
  int   m_mode, m_flag, m_clr, nf;
  logic all_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) begin
        for (int i = 0; i < D + 2; i++) hist[b][i] = 1'b1;
        m_db[b] = 1'b1;
        m_ev[b] = 1'b0;
      end
      m_mode = 1;
      m_flag = 0;
      m_clr  = 0;
    end else begin
      nf = m_flag;
      if (m_flag == 5) begin
        if (m_clr > 1) m_clr = m_clr - 1;
        else nf = 0;
      end
      if (m_ev[0]) begin
        m_mode = (m_mode + 1) % 4;
      end else if (m_ev[1]) begin
        if (m_mode == 1) nf = (m_flag == 7) ? 6 : 7;
      end else if (m_ev[2]) begin
        if (m_mode == 1 && m_flag != 7) begin
          nf = 5;
          m_clr = 2;
        end
      end
      m_flag = nf;
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int i = 0; i <= D; i++) if (hist[b][i] == m_db[b]) all_diff = 1'b0;
        m_ev[b] = all_diff & m_db[b];
        if (all_diff) m_db[b] = ~m_db[b];
        for (int i = 0; i < D + 1; i++) hist[b][i] = hist[b][i+1];
        hist[b][D+1] = bus.btn_n[b];
      end
    end
  end

  always @(negedge clk) begin
    chk("model_state", int'(bus.state), m_mode);
    chk("model_flag", int'(bus.flag), m_flag);
  end

  task automatic drive(input logic [7:0] v);
    @(posedge clk);
    #2;
    bus.btn_n = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic press(input logic [7:0] v);
    drive(v);
    cyc(25);
    drive(8'hFF);
    cyc(30);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    bus.btn_n = 8'hFF;
    cyc(3);
    #2 rst_n = 1'b1;
    cyc(2);
    #1;
    chk("reset_state", int'(bus.state), 1);
    chk("reset_flag", int'(bus.flag), 0);

    // START held: latency D+3 from first sampling edge
    drive(8'hFD);
    cyc(19);
    #1 chk("start_lat_before", int'(bus.flag), 0);
    cyc(1);
    #1 chk("start_lat_at", int'(bus.flag), 7);
    cyc(9);
    drive(8'hFF);
    cyc(30);
    #1 chk("start_held_once", int'(bus.flag), 7);

    press(8'hFD);
    chk("start_pause", int'(bus.flag), 6);

    drive(8'hFD);
    cyc(9);
    drive(8'hFF);
    cyc(30);
    #1 chk("short_pulse", int'(bus.flag), 6);
    for (int r = 0; r < 6; r++) begin
      drive(8'hFD);
      cyc(2);
      drive(8'hFF);
      cyc(2);
    end
    cyc(30);
    #1 chk("bounce", int'(bus.flag), 6);

    // CLEAR from PAUSE: two cycles of CLEAR then IDLE
    drive(8'hFB);
    cyc(20);
    #1 chk("clear_c1", int'(bus.flag), 5);
    cyc(1);
    #1 chk("clear_c2", int'(bus.flag), 5);
    cyc(1);
    #1 chk("clear_idle", int'(bus.flag), 0);
    drive(8'hFF);
    cyc(30);

    press(8'hFD);
    chk("restart_run", int'(bus.flag), 7);
    press(8'hFB);
    chk("clear_in_run", int'(bus.flag), 7);

    for (int i = 0; i < 5; i++) begin
      press(8'hFE);
      chk("mode_seq", int'(bus.state), (2 + i) % 4);
      chk("mode_keeps_run", int'(bus.flag), 7);
    end
    press(8'hFD);
    chk("start_wrong_mode", int'(bus.flag), 7);

    // Asynchronous reset mid-run
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(bus.state), 1);
    chk("async_rst_flag", int'(bus.flag), 0);
    cyc(2);
    #2 rst_n = 1'b1;

    press(8'hFC);
    chk("mode_start_state", int'(bus.state), 2);
    chk("mode_start_flag", int'(bus.flag), 0);

    // Random phase: every cycle is checked against the model
    for (int it = 0; it < 90; it++) begin
      v = 8'($urandom);
      for (int b = 0; b < 3; b++) v[b] = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) v[2:0] = 3'b111;
      drive(v);
      cyc($urandom_range(0, 40));
    end
    drive(8'hFF);
    cyc(40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
